wb_arbiter: RTL and testbench
=============================

// Module: wb_arbiter
// PURPOSE
//   Round-robin arbiter sharing the register file's single write port among N
//   writeback requesters (ALU, load unit, CSR/misc). Sits between the execute/
//   memory stages and reg_file; drives w_en/write_rg/write_data from a register
//   stage. Optionally forwards the in-flight write onto the two read ports.
// PARAMETERS
//   N_REQ   3   number of writeback requesters (2..8)
// PORTS
//   clk          in   1        system clock, rising edge
//   rst          in   1        asynchronous, active-low reset
//   hold         in   1        1 = grant nothing this cycle (pipeline stall/flush)
//   req_valid    in   N_REQ    requester i has a write pending
//   req_ready    out  N_REQ    one-hot grant; handshake = valid[i] & ready[i]
//   req_rg       in   5*N_REQ  dest register of requester i (bits 5i+:5)
//   req_data     in   32*N_REQ write data of requester i (bits 32i+:32)
//   w_en         out  1        to reg_file write enable (registered)
//   write_rg     out  5        to reg_file write register (registered)
//   write_data   out  32       to reg_file write data (registered)
//   grant_id     out  3        index of requester owning current w_en (registered)
//   read1_rg     in   5        reg_file read port 1 address (forwarding)
//   read1_raw    in   32       reg_file read1 data
//   read1_fwd    out  32       read1 data after forwarding
//   read2_rg     in   5        reg_file read port 2 address
//   read2_raw    in   32       reg_file read2 data
//   read2_fwd    out  32       read2 data after forwarding
// BEHAVIOUR
//   - Reset (rst=0, async): ptr=0, w_en=0, write_rg=0, write_data=0, grant_id=0.
//     An in-flight write is discarded; req_ready=0 while rst=0.
//   - Arbitration (combinational): if hold=0, grant lowest index k scanning
//     ptr, ptr+1, ... mod N_REQ with req_valid[k]=1; req_ready=1<<k. None valid
//     or hold=1 -> req_ready=0.
//   - Pointer: on handshake with k, ptr <= (k+1) mod N_REQ; else ptr holds.
//   - Requester rule: req_valid, req_rg, req_data stable until handshake.
//     No backpressure from reg_file; at most one handshake per cycle.
//   - Latency: handshake in cycle t -> w_en=1, write_rg/write_data/grant_id
//     loaded at edge ending t, valid for cycle t+1; reg_file commits at edge
//     ending t+1. No handshake in cycle t -> w_en=0 in t+1 (rg/data/id hold).
//   - rg=0: handshake accepted (ready given, ptr advances), but w_en=0 next
//     cycle; write_rg/write_data still loaded.
//   - Back-to-back: handshakes every cycle sustain w_en=1 every cycle.
//   - Fairness: continuously valid requester granted within N_REQ cycles of
//     hold=0.
//   - hold asserted mid-stream: no new grants; the already registered write
//     still issues in the next cycle.
//   - grant_id width fixed at 3 bits; upper bits zero for small N_REQ.
// CONFIGURATION
//   WB_ARB_FWD_EN defined: readX_fwd = write_data when w_en=1, write_rg==readX_rg
//     and readX_rg!=0; else readX_raw. Covers same-cycle read of a value being
//     written this cycle.
//   WB_ARB_FWD_EN undefined: readX_fwd = readX_raw (pure pass-through); ports
//     remain present.
// TESTING
//   1 reset: rst=0 with all valid=1 -> req_ready=0, w_en=0, outputs 0;
//     release -> requester 0 granted first.
//   2 single: valid[1]=1, rg=5, data=32'hDEADBEEF at t -> ready[1] at t;
//     t+1 w_en=1, write_rg=5, write_data=DEADBEEF, grant_id=1.
//   3 round-robin: all 3 valid for 6 cycles -> grants 0,1,2,0,1,2;
//     w_en=1 continuously from cycle 2.
//   4 x0 drop: valid[2]=1, rg=0, data=32'h1234 -> ready[2]=1, next cycle w_en=0,
//     ptr becomes 0.
//   5 hold/reset mid-op: hold=1 with valids -> no ready, registered write still
//     issues; rst=0 while w_en=1 -> w_en=0 immediately (async).
//   6 forward (WB_ARB_FWD_EN): w_en=1, write_rg=3, data=32'hFEEDFEED, read1_rg=3,
//     read1_raw=0 -> read1_fwd=FEEDFEED; read2_rg=0 -> read2_fwd=read2_raw;
//     macro off -> read1_fwd=0.

Source files
------------

// File: rtl/wb_arbiter_if.sv
// Writeback arbiter bus: requester handshakes, reg_file write port and read-forwarding taps.
// The arbiter uses the slave modport; the requester/reg_file side uses master.
interface wb_arbiter_if #(
    parameter int unsigned N_REQ = 3
) ();
    logic                  hold;
    logic [N_REQ-1:0]      req_valid;
    logic [N_REQ-1:0]      req_ready;
    logic [5*N_REQ-1:0]    req_rg;
    logic [32*N_REQ-1:0]   req_data;
    logic                  w_en;
    logic [4:0]            write_rg;
    logic [31:0]           write_data;
    logic [2:0]            grant_id;
    logic [4:0]            read1_rg;
    logic [31:0]           read1_raw;
    logic [31:0]           read1_fwd;
    logic [4:0]            read2_rg;
    logic [31:0]           read2_raw;
    logic [31:0]           read2_fwd;

    modport master (
        output hold, req_valid, req_rg, req_data,
        output read1_rg, read1_raw, read2_rg, read2_raw,
        input  req_ready, w_en, write_rg, write_data, grant_id,
        input  read1_fwd, read2_fwd
    );

    modport slave (
        input  hold, req_valid, req_rg, req_data,
        input  read1_rg, read1_raw, read2_rg, read2_raw,
        output req_ready, w_en, write_rg, write_data, grant_id,
        output read1_fwd, read2_fwd
    );
endinterface

// File: rtl/wb_arbiter.sv
// Round-robin arbiter for the single reg_file write port, with a registered write stage.
// Define WB_ARB_FWD_EN to forward the in-flight write onto both read ports.
module wb_arbiter #(
    parameter int unsigned N_REQ = 3
) (
    input logic         clk,
    input logic         rst,
    wb_arbiter_if.slave bus
);
    localparam int unsigned MaxReq = 8;

    logic [MaxReq-1:0] valid_ext;
    logic [4:0]        rg_arr   [MaxReq];
    logic [31:0]       data_arr [MaxReq];

    // Pad requesters out to 8 so a 3-bit index never selects outside a vector.
    for (genvar g = 0; g < MaxReq; g++) begin : g_pad
        if (g < N_REQ) begin : g_req
            assign valid_ext[g] = bus.req_valid[g];
            assign rg_arr[g]    = bus.req_rg[5*g +: 5];
            assign data_arr[g]  = bus.req_data[32*g +: 32];
        end else begin : g_none
            assign valid_ext[g] = 1'b0;
            assign rg_arr[g]    = 5'd0;
            assign data_arr[g]  = 32'd0;
        end
    end

    logic [2:0]  ptr_q, ptr_d;
    logic        w_en_q, w_en_d;
    logic [4:0]  write_rg_q, write_rg_d;
    logic [31:0] write_data_q, write_data_d;
    logic [2:0]  grant_id_q, grant_id_d;

    logic        found;
    logic [2:0]  gnt_idx;
    logic [3:0]  pos;
    logic        hs;
    logic [7:0]  ready_ext;

    always_comb begin
        found   = 1'b0;
        gnt_idx = 3'd0;
        pos     = 4'd0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            pos = {1'b0, ptr_q} + 4'(i);
            if (pos >= 4'(N_REQ)) begin
                pos = pos - 4'(N_REQ);
            end
            if (!found && valid_ext[pos[2:0]]) begin
                found   = 1'b1;
                gnt_idx = pos[2:0];
            end
        end
    end

    assign hs            = rst && !bus.hold && found;
    assign ready_ext     = hs ? (8'd1 << gnt_idx) : 8'd0;
    assign bus.req_ready = ready_ext[N_REQ-1:0];

    always_comb begin
        ptr_d        = ptr_q;
        w_en_d       = 1'b0;
        write_rg_d   = write_rg_q;
        write_data_d = write_data_q;
        grant_id_d   = grant_id_q;
        if (hs) begin
            ptr_d        = (gnt_idx == 3'(N_REQ - 1)) ? 3'd0 : gnt_idx + 3'd1;
            // x0 is accepted and loaded but never written
            w_en_d       = (rg_arr[gnt_idx] != 5'd0);
            write_rg_d   = rg_arr[gnt_idx];
            write_data_d = data_arr[gnt_idx];
            grant_id_d   = gnt_idx;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q        <= 3'd0;
            w_en_q       <= 1'b0;
            write_rg_q   <= 5'd0;
            write_data_q <= 32'd0;
            grant_id_q   <= 3'd0;
        end else begin
            ptr_q        <= ptr_d;
            w_en_q       <= w_en_d;
            write_rg_q   <= write_rg_d;
            write_data_q <= write_data_d;
            grant_id_q   <= grant_id_d;
        end
    end

    assign bus.w_en       = w_en_q;
    assign bus.write_rg   = write_rg_q;
    assign bus.write_data = write_data_q;
    assign bus.grant_id   = grant_id_q;

`ifdef WB_ARB_FWD_EN
    assign bus.read1_fwd = (w_en_q && write_rg_q == bus.read1_rg && bus.read1_rg != 5'd0)
                           ? write_data_q : bus.read1_raw;
    assign bus.read2_fwd = (w_en_q && write_rg_q == bus.read2_rg && bus.read2_rg != 5'd0)
                           ? write_data_q : bus.read2_raw;
`else
    logic unused_read_rg;
    assign unused_read_rg = ^{bus.read1_rg, bus.read2_rg};
    assign bus.read1_fwd  = bus.read1_raw;
    assign bus.read2_fwd  = bus.read2_raw;
`endif
endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: a queue-free round-robin model checked every cycle,
// plus literal expectations along the directed sequence.
module tb_wb_arbiter;
    localparam int N = 3;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    wb_arbiter_if #(.N_REQ(N)) bus ();

    wb_arbiter #(.N_REQ(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model state: what the write stage must hold, and the round-robin start point.
    int          m_ptr;
    logic        m_wen;
    logic [4:0]  m_rg;
    logic [31:0] m_data;
    logic [2:0]  m_id;

    function automatic int model_grant();
        if (!rst || bus.hold) return -1;
        for (int o = 0; o < N; o++) begin
            if (bus.req_valid[(m_ptr + o) % N]) return (m_ptr + o) % N;
        end
        return -1;
    endfunction

    function automatic logic [4:0] rg_of(input int k);
        return bus.req_rg[5*k +: 5];
    endfunction

    function automatic logic [31:0] data_of(input int k);
        return bus.req_data[32*k +: 32];
    endfunction

    function automatic logic [2:0] model_ready();
        int g;
        g = model_grant();
        return (g < 0) ? 3'd0 : 3'(1 << g);
    endfunction

    function automatic logic [31:0] model_fwd(input logic [4:0] rg, input logic [31:0] raw);
`ifdef WB_ARB_FWD_EN
        if (m_wen && m_rg == rg && rg != 5'd0) return m_data;
`endif
        return raw;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_ptr  <= 0;
            m_wen  <= 1'b0;
            m_rg   <= 5'd0;
            m_data <= 32'd0;
            m_id   <= 3'd0;
        end else if (model_grant() >= 0) begin
            m_ptr  <= (model_grant() + 1) % N;
            m_wen  <= (rg_of(model_grant()) != 5'd0);
            m_rg   <= rg_of(model_grant());
            m_data <= data_of(model_grant());
            m_id   <= 3'(model_grant());
        end else begin
            m_wen  <= 1'b0;
        end
    end

    always @(negedge clk) begin
        chk("cyc_ready", 32'(bus.req_ready), 32'(model_ready()));
        chk("cyc_w_en", 32'(bus.w_en), 32'(m_wen));
        chk("cyc_write_rg", 32'(bus.write_rg), 32'(m_rg));
        chk("cyc_write_data", bus.write_data, m_data);
        chk("cyc_grant_id", 32'(bus.grant_id), 32'(m_id));
        chk("cyc_read1_fwd", bus.read1_fwd, model_fwd(bus.read1_rg, bus.read1_raw));
        chk("cyc_read2_fwd", bus.read2_fwd, model_fwd(bus.read2_rg, bus.read2_raw));
    end

    task automatic to_pos();
        @(posedge clk);
        #1;
    endtask

    task automatic to_neg();
        @(negedge clk);
        #1;
    endtask

    task automatic set_req(input int k, input logic [4:0] rg, input logic [31:0] data);
        bus.req_rg[5*k +: 5]    = rg;
        bus.req_data[32*k +: 32] = data;
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        m_ptr     = 0;
        m_wen     = 1'b0;
        m_rg      = 5'd0;
        m_data    = 32'd0;
        m_id      = 3'd0;
        rst       = 1'b1;
        bus.hold      = 1'b0;
        bus.req_valid = '0;
        bus.req_rg    = '0;
        bus.req_data  = '0;
        bus.read1_rg  = 5'd0;
        bus.read1_raw = 32'd0;
        bus.read2_rg  = 5'd0;
        bus.read2_raw = 32'd0;
        #2 rst = 1'b0;
        to_pos();
        to_pos();

        // Reset with every requester valid
        set_req(0, 5'd1, 32'hA0A0_A0A0);
        set_req(1, 5'd2, 32'hA1A1_A1A1);
        set_req(2, 5'd3, 32'hA2A2_A2A2);
        bus.req_valid = 3'b111;
        to_neg();
        chk("rst_ready", 32'(bus.req_ready), 32'h0);
        chk("rst_w_en", 32'(bus.w_en), 32'h0);
        chk("rst_write_rg", 32'(bus.write_rg), 32'h0);
        chk("rst_write_data", bus.write_data, 32'h0);
        chk("rst_grant_id", 32'(bus.grant_id), 32'h0);
        rst = 1'b1;
        #1;
        chk("rel_ready", 32'(bus.req_ready), 32'h1);
        to_pos();
        bus.req_valid = 3'b000;
        to_neg();
        chk("rel_w_en", 32'(bus.w_en), 32'h1);
        chk("rel_grant_id", 32'(bus.grant_id), 32'h0);

        // Single request from requester 1
        set_req(1, 5'd5, 32'hDEAD_BEEF);
        bus.req_valid = 3'b010;
        #1;
        chk("single_ready", 32'(bus.req_ready), 32'h2);
        to_pos();
        bus.req_valid = 3'b000;
        to_neg();
        chk("single_w_en", 32'(bus.w_en), 32'h1);
        chk("single_write_rg", 32'(bus.write_rg), 32'd5);
        chk("single_write_data", bus.write_data, 32'hDEAD_BEEF);
        chk("single_grant_id", 32'(bus.grant_id), 32'd1);
        to_neg();
        chk("idle_w_en", 32'(bus.w_en), 32'h0);
        chk("idle_write_rg_hold", 32'(bus.write_rg), 32'd5);

        // x0 destination from requester 2 (pointer now at 2)
        set_req(2, 5'd0, 32'h0000_1234);
        bus.req_valid = 3'b100;
        #1;
        chk("x0_ready", 32'(bus.req_ready), 32'h4);
        to_pos();
        bus.req_valid = 3'b000;
        to_neg();
        chk("x0_w_en", 32'(bus.w_en), 32'h0);
        chk("x0_write_rg", 32'(bus.write_rg), 32'h0);
        chk("x0_write_data", bus.write_data, 32'h0000_1234);
        chk("x0_grant_id", 32'(bus.grant_id), 32'd2);

        // Round robin with all valid; pointer must have wrapped to 0
        set_req(0, 5'd1, 32'h1111_0000);
        set_req(1, 5'd2, 32'h2222_0000);
        set_req(2, 5'd3, 32'h3333_0000);
        bus.req_valid = 3'b111;
        for (int c = 0; c < 6; c++) begin
            #1;
            chk("rr_ready", 32'(bus.req_ready), 32'(1 << (c % 3)));
            to_pos();
            to_neg();
            chk("rr_w_en", 32'(bus.w_en), 32'h1);
            chk("rr_grant_id", 32'(bus.grant_id), 32'(c % 3));
        end

        // Hold mid-stream: registered write still issues, nothing new granted
        bus.hold = 1'b1;
        #1;
        chk("hold_ready", 32'(bus.req_ready), 32'h0);
        chk("hold_w_en_issues", 32'(bus.w_en), 32'h1);
        to_pos();
        to_neg();
        chk("hold_w_en_drains", 32'(bus.w_en), 32'h0);
        chk("hold_write_rg", 32'(bus.write_rg), 32'd3);
        bus.hold = 1'b0;
        #1;
        chk("unhold_ready", 32'(bus.req_ready), 32'h1);
        to_pos();
        chk("pre_rst_w_en", 32'(bus.w_en), 32'h1);
        #1;
        rst = 1'b0;
        #1;
        chk("async_rst_w_en", 32'(bus.w_en), 32'h0);
        chk("async_rst_ready", 32'(bus.req_ready), 32'h0);
        chk("async_rst_write_rg", 32'(bus.write_rg), 32'h0);
        bus.req_valid = 3'b000;
        to_neg();
        rst = 1'b1;
        to_pos();

        // Forwarding of the in-flight write
        set_req(0, 5'd3, 32'hFEED_FEED);
        bus.req_valid = 3'b001;
        bus.read1_rg  = 5'd3;
        bus.read1_raw = 32'h0;
        bus.read2_rg  = 5'd0;
        bus.read2_raw = 32'h55AA_55AA;
        to_pos();
        bus.req_valid = 3'b000;
        to_neg();
        chk("fwd_w_en", 32'(bus.w_en), 32'h1);
`ifdef WB_ARB_FWD_EN
        chk("fwd_read1", bus.read1_fwd, 32'hFEED_FEED);
`else
        chk("fwd_read1", bus.read1_fwd, 32'h0);
`endif
        chk("fwd_read2_x0", bus.read2_fwd, 32'h55AA_55AA);
        bus.read2_rg  = 5'd3;
        bus.read2_raw = 32'h1111_1111;
        #1;
`ifdef WB_ARB_FWD_EN
        chk("fwd_read2", bus.read2_fwd, 32'hFEED_FEED);
`else
        chk("fwd_read2", bus.read2_fwd, 32'h1111_1111);
`endif
        bus.read1_raw = 32'h0000_0022;
        to_pos();
        to_neg();
        chk("fwd_idle_read1", bus.read1_fwd, 32'h0000_0022);
        to_pos();
        to_pos();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
